// File: rtl/nibble_loader_pkg.sv
// Shared types and defaults for the nibble-serial channel loader.
// Holds the loader FSM state encoding and default nibble/channel widths.
package nibble_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W_DEF = 4;
  localparam int CH_W_DEF  = 128;

  function automatic int nib_count(input int ch_w, input int nib_w);
    return ch_w / nib_w;
  endfunction

endpackage

// File: rtl/nibble_shift_chan.sv
// One loader channel: a nibble shift register, MSB-nibble first.
// Ports: clk, rst_n (sync, active low), shift_en, commit, clr, din, q.
// Build option SHADOW_EN: q comes from a shadow register that is
// loaded atomically on commit; otherwise q is the live shift register.
module nibble_shift_chan
  import nibble_loader_pkg::*;
#(
  parameter int NIB_W = NIB_W_DEF,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             commit,
  input  logic             clr,
  input  logic [NIB_W-1:0] din,
  output logic [CH_W-1:0]  q
);

  logic [CH_W-1:0] sh;
  logic [CH_W-1:0] nxt;

  assign nxt = {sh[CH_W-NIB_W-1:0], din};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (clr) begin
      sh <= '0;
    end else if (shift_en) begin
      sh <= nxt;
    end
  end

`ifdef SHADOW_EN
  logic [CH_W-1:0] shadow;

  // commit coincides with the final shift, so take the
  // post-shift value directly rather than waiting a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (commit) begin
      shadow <= nxt;
    end
  end

  assign q = shadow;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign q = sh;
`endif

endmodule

// File: rtl/nibble_chan_loader.sv
// Multi-channel nibble-serial register loader with frame handshake.
// Ports: clk, rst_n, frame, sel, wr_stb, din, clr -> regs, ch_full,
// busy, err_ovf, err_short. Build option SHADOW_EN (see channel).
module nibble_chan_loader
  import nibble_loader_pkg::*;
#(
  parameter int NIB_W  = NIB_W_DEF,
  parameter int NUM_CH = 2,
  parameter int CH_W   = CH_W_DEF,
  parameter int SEL_W  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   wr_stb,
  input  logic [NIB_W-1:0]       din,
  input  logic                   clr,
  output logic [NUM_CH*CH_W-1:0] regs,
  output logic [NUM_CH-1:0]      ch_full,
  output logic                   busy,
  output logic                   err_ovf,
  output logic                   err_short
);

  localparam int NNIB  = nib_count(CH_W, NIB_W);
  localparam int CNT_W = $clog2(NNIB + 1);

  state_t             state;
  logic [SEL_W-1:0]   ch;
  logic [CNT_W-1:0]   cnt;

  logic               stb_load;
  logic               last;
  logic               clr_idle;
  logic [NUM_CH-1:0]  sel_mask;
  logic [NUM_CH-1:0]  ch_mask;
  logic [NUM_CH-1:0]  shift_en;
  logic [NUM_CH-1:0]  commit;
  logic [NUM_CH-1:0]  clr_ch;

  assign stb_load = (state == LOAD) && wr_stb;
  assign last     = (cnt == CNT_W'(NNIB - 1));
  assign clr_idle = (state == IDLE) && !frame && clr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel_mask[k] = (sel == SEL_W'(k));
    assign ch_mask[k]  = (ch == SEL_W'(k));
    assign shift_en[k] = stb_load && ch_mask[k];
    assign commit[k]   = shift_en[k] && last;
    assign clr_ch[k]   = clr_idle && sel_mask[k];

    nibble_shift_chan #(
      .NIB_W (NIB_W),
      .CH_W  (CH_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en[k]),
      .commit   (commit[k]),
      .clr      (clr_ch[k]),
      .din      (din),
      .q        (regs[k*CH_W +: CH_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      cnt       <= '0;
      ch_full   <= '0;
      busy      <= 1'b0;
      err_ovf   <= 1'b0;
      err_short <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame) begin
            ch        <= sel;
            cnt       <= '0;
            ch_full   <= ch_full & ~sel_mask;
            err_ovf   <= 1'b0;
            err_short <= 1'b0;
            state     <= LOAD;
            busy      <= 1'b1;
          end else if (clr) begin
            ch_full <= ch_full & ~sel_mask;
          end
        end
        LOAD: begin
          if (wr_stb) begin
            cnt <= cnt + CNT_W'(1);
          end
          // A completing strobe wins over a simultaneous frame drop:
          // the channel is full, so the frame was not short.
          if (wr_stb && last) begin
            ch_full <= ch_full | ch_mask;
            state   <= frame ? DONE : IDLE;
            busy    <= frame;
          end else if (!frame) begin
            err_short <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (wr_stb) begin
            err_ovf <= 1'b1;
          end
          if (!frame) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_chan_loader.sv
// Randomized and directed bench for nibble_chan_loader (2 x 32-bit).
// Compares every output each cycle against a nibble-level reference.
module tb_nibble_chan_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame;
  logic [0:0]  sel;
  logic        wr_stb;
  logic [3:0]  din;
  logic        clr;
  logic [63:0] regs;
  logic [1:0]  ch_full;
  logic        busy;
  logic        err_ovf;
  logic        err_short;

  nibble_chan_loader #(
    .NIB_W  (4),
    .NUM_CH (2),
    .CH_W   (32),
    .SEL_W  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame     (frame),
    .sel       (sel),
    .wr_stb    (wr_stb),
    .din       (din),
    .clr       (clr),
    .regs      (regs),
    .ch_full   (ch_full),
    .busy      (busy),
    .err_ovf   (err_ovf),
    .err_short (err_short)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: nibble values held per channel, a running count
  // of nibbles received in the current frame, and flags.
  bit [31:0] m_live [2];
  bit [31:0] m_shown [2];
  bit        m_full [2];
  bit        m_active;
  bit        m_complete;
  int        m_n;
  int        m_ch;
  bit        m_eo;
  bit        m_es;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] m_reg(input int k);
`ifdef SHADOW_EN
    return m_shown[k];
`else
    return m_live[k];
`endif
  endfunction

  task automatic model(input bit f, input int s, input bit stb,
                       input bit [3:0] d, input bit c, input bit r);
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        m_live[k] = 0; m_shown[k] = 0; m_full[k] = 0;
      end
      m_active = 0; m_complete = 0; m_n = 0;
      m_ch = 0; m_eo = 0; m_es = 0;
    end else if (!m_active) begin
      if (f) begin
        m_active = 1; m_complete = 0; m_n = 0;
        m_ch = s; m_full[s] = 0; m_eo = 0; m_es = 0;
      end else if (c) begin
        m_live[s] = 0; m_shown[s] = 0; m_full[s] = 0;
      end
    end else if (!m_complete) begin
      if (stb) begin
        m_live[m_ch] = m_live[m_ch] * 16 + 32'(d);
        m_n++;
        if (m_n == 8) begin
          m_complete = 1;
          m_full[m_ch] = 1;
          m_shown[m_ch] = m_live[m_ch];
          if (!f) m_active = 0;
        end
      end
      if (!f && !m_complete) begin
        m_es = 1; m_active = 0;
      end
    end else begin
      if (stb) m_eo = 1;
      if (!f) m_active = 0;
    end
  endtask

  task automatic check_all();
    chk("regs", regs, {m_reg(1), m_reg(0)});
    chk("ch_full", 64'(ch_full), 64'({m_full[1], m_full[0]}));
    chk("busy", 64'(busy), 64'(m_active));
    chk("err_ovf", 64'(err_ovf), 64'(m_eo));
    chk("err_short", 64'(err_short), 64'(m_es));
  endtask

  task automatic step(input bit f, input int s, input bit stb,
                      input bit [3:0] d, input bit c, input bit r);
    frame = f; sel = 1'(s); wr_stb = stb;
    din = d; clr = c; rst_n = r;
    @(posedge clk);
    model(f, s, stb, d, c, r);
    #1;
    check_all();
  endtask

  logic [31:0] saved;
  bit          rf;

  initial begin
    frame = 0; sel = 0; wr_stb = 0;
    din = 0; clr = 0; rst_n = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // 1: full load of channel 0
    step(1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 4'(i), 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t1_reg0", 64'(regs[31:0]), 64'h12345678);
    chk("t1_full", 64'(ch_full), 64'h1);
    chk("t1_busy", 64'(busy), 64'h0);

    // 6: clear channel 0 from idle
    step(0, 0, 0, 0, 1, 1);
    chk("t6_reg0", 64'(regs[31:0]), 64'h0);
    chk("t6_full", 64'(ch_full), 64'h0);

    // 2: short frame on channel 1
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 4'hA, 0, 1);
    step(1, 1, 1, 4'hB, 0, 1);
    step(1, 1, 1, 4'hC, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("t2_short", 64'(err_short), 64'h1);
    chk("t2_full1", 64'(ch_full[1]), 64'h0);
`ifdef SHADOW_EN
    chk("t2_reg1", 64'(regs[63:32]), 64'h0);
`else
    chk("t2_reg1", 64'(regs[63:32]), 64'hABC);
`endif

    // 3: overflow strobe, then next frame clears it
    step(1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) step(1, 0, 1, 4'(i), 0, 1);
    chk("t3_reg0", 64'(regs[31:0]), 64'h12345678);
    chk("t3_ovf", 64'(err_ovf), 64'h1);
    step(0, 0, 0, 0, 0, 1);

    // 6b + 4: clr with frame is ignored; sel toggles mid-frame
    saved = regs[63:32];
    step(1, 0, 0, 0, 1, 1);
    chk("t6b_reg0", 64'(regs[31:0]), 64'h12345678);
    chk("t3_ovf_clr", 64'(err_ovf), 64'h0);
    chk("t6b_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 8; i++) step(1, i % 2, 1, 4'(8 - i), 1, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("t4_reg0", 64'(regs[31:0]), 64'h87654321);
    chk("t4_reg1", 64'(regs[63:32]), 64'(saved));

    // 5: reset mid-frame
    step(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 4'(i + 3), 0, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("t5_regs", regs, 64'h0);
    chk("t5_full", 64'(ch_full), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);

    // Random traffic
    rf = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) rf = ~rf;
      step(rf, int'($urandom_range(0, 1)),
           $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 299) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
